// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: deserialises CMD_W+DATA_W bit frames from MOSI and
// serialises RAM read data onto MISO, with a bounded wait for tx_valid.
`timescale 1ns/1ps
module spi_slave_param #(
    parameter int CMD_W      = 2,
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      SS_n,
    input  logic                      MOSI,
    input  logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_valid,
    output logic                      MISO,
    output logic [CMD_W+DATA_W-1:0]   rx_data,
    output logic                      rx_valid,
    output logic                      rd_pending,
    output logic                      frame_err
);
    localparam int F  = CMD_W + DATA_W;
    localparam int CW = $clog2(F + 1);
    localparam int TW = $clog2(TX_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(F - 1);
    localparam logic [CW-1:0] DCNT = CW'(DATA_W);
    localparam logic [TW-1:0] TMAX = TW'(TX_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, HOLD
    } state_t;

    state_t            state, next;
    logic [CW-1:0]     cnt;
    logic [TW-1:0]     tcnt;
    logic [F-2:0]      sh;
    logic [F-1:0]      sh_next;
    logic [DATA_W-1:0] txsh;
    logic              shifting, last_bit, tmo, abort;

    assign sh_next  = {sh, MOSI};
    assign shifting = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    assign last_bit = shifting && (cnt == LAST);
    assign tmo      = (tcnt + 1'b1) == TMAX;
    assign abort    = SS_n && (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        if (abort) begin
            next = IDLE;
        end else begin
            case (state)
                IDLE:      if (!SS_n) next = CHK_CMD;
                CHK_CMD:   next = MOSI ? (rd_pending ? READ_DATA : READ_ADD) : WRITE;
                WRITE,
                READ_ADD:  if (last_bit) next = HOLD;
                READ_DATA: if (last_bit) next = WAIT_TX;
                WAIT_TX: begin
                    if (tx_valid) next = SEND;
                    else if (tmo) next = HOLD;
                end
                SEND:      if (cnt == DCNT) next = HOLD;
                default:   next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            tcnt       <= '0;
            sh         <= '0;
            txsh       <= '0;
            MISO       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rd_pending <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (abort) begin
                // rd_pending is deliberately untouched so an aborted read can be retried
                cnt       <= '0;
                MISO      <= 1'b0;
                frame_err <= shifting || (state == WAIT_TX) || (state == SEND);
            end else begin
                case (state)
                    IDLE: begin
                        cnt  <= '0;
                        MISO <= 1'b0;
                    end
                    CHK_CMD: begin
                        sh  <= sh_next[F-2:0];
                        cnt <= CW'(1);
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        sh <= sh_next[F-2:0];
                        if (last_bit) begin
                            rx_data  <= sh_next;
                            rx_valid <= 1'b1;
                            cnt      <= '0;
                            tcnt     <= '0;
                            if (state == READ_ADD) rd_pending <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WAIT_TX: begin
                        if (tx_valid) begin
                            MISO <= tx_data[DATA_W-1];
                            txsh <= tx_data << 1;
                            cnt  <= CW'(1);
                        end else begin
                            tcnt <= tcnt + 1'b1;
                            if (tmo) begin
                                frame_err  <= 1'b1;
                                rd_pending <= 1'b0;
                            end
                        end
                    end
                    SEND: begin
                        if (cnt == DCNT) begin
                            MISO       <= 1'b0;
                            rd_pending <= 1'b0;
                            cnt        <= '0;
                        end else begin
                            MISO <= txsh[DATA_W-1];
                            txsh <= txsh << 1;
                            cnt  <= cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_param.sv
// Scoreboard bench for spi_slave_param: default 10-bit instance plus a
// DATA_W=16 instance; strobes and every MISO cycle are checked against queues.
`timescale 1ns/1ps
module tb_spi_slave_param;
    typedef struct {
        int unsigned cyc;
        bit          is_err;
        logic [31:0] data;
    } ev_t;
    typedef struct {
        int unsigned cyc;
        logic        b;
    } bit_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ss0, mosi0, txv0, ss1, mosi1, txv1;
    logic [7:0]  txd0;
    logic [15:0] txd1;
    logic        miso0, rxv0, rdp0, ferr0, miso1, rxv1, rdp1, ferr1;
    logic [9:0]  rxd0;
    logic [17:0] rxd1;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    ev_t         evq0[$], evq1[$];
    bit_t        mq0[$], mq1[$];
    ev_t         m0, m1;
    logic        mexp0, mexp1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_slave_param dut0 (
        .clk(clk), .rst(rst), .SS_n(ss0), .MOSI(mosi0), .tx_data(txd0), .tx_valid(txv0),
        .MISO(miso0), .rx_data(rxd0), .rx_valid(rxv0), .rd_pending(rdp0), .frame_err(ferr0)
    );

    spi_slave_param #(.CMD_W(2), .DATA_W(16), .TX_TIMEOUT(16)) dut1 (
        .clk(clk), .rst(rst), .SS_n(ss1), .MOSI(mosi1), .tx_data(txd1), .tx_valid(txv1),
        .MISO(miso1), .rx_data(rxd1), .rx_valid(rxv1), .rd_pending(rdp1), .frame_err(ferr1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int inst, input int unsigned c, input bit is_err, input logic [31:0] d);
        ev_t e;
        e.cyc = c;
        e.is_err = is_err;
        e.data = d;
        if (inst == 0) evq0.push_back(e);
        else           evq1.push_back(e);
    endtask

    task automatic push_bit(input int inst, input int unsigned c, input logic b);
        bit_t e;
        e.cyc = c;
        e.b = b;
        if (inst == 0) mq0.push_back(e);
        else           mq1.push_back(e);
    endtask

    task automatic set_in(input int inst, input logic s, input logic m);
        if (inst == 0) begin ss0 = s; mosi0 = m; end
        else           begin ss1 = s; mosi1 = m; end
    endtask

    task automatic deselect(input int inst);
        set_in(inst, 1'b1, 1'b0);
        tick();
    endtask

    // Frame bit F-1 is sampled one edge after the select edge, bit 0 F edges after it.
    task automatic do_frame(input int inst, input int f, input logic [31:0] val, input int extra);
        push_ev(inst, cyc + 1 + int'(f), 1'b0, val);
        set_in(inst, 1'b0, 1'b0);
        tick();
        for (int i = f - 1; i >= 0; i--) begin
            set_in(inst, 1'b0, val[i]);
            tick();
        end
        for (int i = 0; i < extra; i++) begin
            set_in(inst, 1'b0, 1'b1);
            tick();
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rxv0 || ferr0) begin
                if (evq0.size() == 0) begin
                    chk("unexpected_strobe0", {30'd0, rxv0, ferr0}, 32'd0);
                end else begin
                    m0 = evq0.pop_front();
                    chk("strobe_cycle0", cyc, m0.cyc);
                    chk("strobe_kind0", {30'd0, rxv0, ferr0}, m0.is_err ? 32'd1 : 32'd2);
                    if (!m0.is_err) chk("rx_data0", {22'd0, rxd0}, m0.data);
                end
            end
            mexp0 = 1'b0;
            if (mq0.size() > 0 && mq0[0].cyc == cyc) begin
                mexp0 = mq0[0].b;
                void'(mq0.pop_front());
            end
            chk("miso0", {31'd0, miso0}, {31'd0, mexp0});
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rxv1 || ferr1) begin
                if (evq1.size() == 0) begin
                    chk("unexpected_strobe1", {30'd0, rxv1, ferr1}, 32'd0);
                end else begin
                    m1 = evq1.pop_front();
                    chk("strobe_cycle1", cyc, m1.cyc);
                    chk("strobe_kind1", {30'd0, rxv1, ferr1}, m1.is_err ? 32'd1 : 32'd2);
                    if (!m1.is_err) chk("rx_data1", {14'd0, rxd1}, m1.data);
                end
            end
            mexp1 = 1'b0;
            if (mq1.size() > 0 && mq1[0].cyc == cyc) begin
                mexp1 = mq1[0].b;
                void'(mq1.pop_front());
            end
            chk("miso1", {31'd0, miso1}, {31'd0, mexp1});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  rd8;
        logic [15:0] rd16;
        logic [4:0]  ab;
        rst = 1'b1;
        ss0 = 1'b1; mosi0 = 1'b0; txv0 = 1'b0; txd0 = '0;
        ss1 = 1'b1; mosi1 = 1'b0; txv1 = 1'b0; txd1 = '0;
        repeat (3) tick();
        chk("rst_miso", {31'd0, miso0}, 32'd0);
        chk("rst_rx_data", {22'd0, rxd0}, 32'd0);
        chk("rst_rx_valid", {31'd0, rxv0}, 32'd0);
        chk("rst_rd_pending", {31'd0, rdp0}, 32'd0);
        chk("rst_frame_err", {31'd0, ferr0}, 32'd0);
        chk("rst_rx_data1", {14'd0, rxd1}, 32'd0);
        rst = 1'b0;
        tick();

        // write frame 0_0_10100101
        do_frame(0, 10, 32'h0A5, 0);
        chk("write_rd_pending", {31'd0, rdp0}, 32'd0);
        deselect(0);

        // read address then read data, tx_valid two cycles after the frame
        do_frame(0, 10, 32'h20F, 0);
        chk("rdadd_rd_pending", {31'd0, rdp0}, 32'd1);
        deselect(0);
        do_frame(0, 10, 32'h300, 0);
        tick();
        rd8 = 8'hC3;
        txv0 = 1'b1; txd0 = rd8;
        for (int k = 0; k < 8; k++) push_bit(0, cyc + 1 + k, rd8[7-k]);
        tick();
        txv0 = 1'b0; txd0 = '0;
        repeat (10) tick();
        chk("read_done_rd_pending", {31'd0, rdp0}, 32'd0);
        deselect(0);

        // timeout: frame_err exactly 16 edges after WAIT_TX entry
        do_frame(0, 10, 32'h2AA, 0);
        deselect(0);
        do_frame(0, 10, 32'h355, 0);
        push_ev(0, cyc + 16, 1'b1, 32'd0);
        repeat (20) tick();
        chk("timeout_rd_pending", {31'd0, rdp0}, 32'd0);
        deselect(0);

        // abort while waiting for read data keeps rd_pending
        do_frame(0, 10, 32'h2AA, 0);
        deselect(0);
        do_frame(0, 10, 32'h355, 0);
        repeat (2) tick();
        push_ev(0, cyc + 1, 1'b1, 32'd0);
        deselect(0);
        chk("waittx_abort_rd_pending", {31'd0, rdp0}, 32'd1);

        // abort after 5 bits of a write frame
        push_ev(0, cyc + 7, 1'b1, 32'd0);
        set_in(0, 1'b0, 1'b0);
        tick();
        ab = 5'b00101;
        for (int i = 4; i >= 0; i--) begin
            set_in(0, 1'b0, ab[i]);
            tick();
        end
        deselect(0);
        tick();
        chk("abort_rx_data_kept", {22'd0, rxd0}, 32'h355);
        chk("abort_rd_pending", {31'd0, rdp0}, 32'd1);

        // 14 bits under one select: only the first 10 form a frame
        do_frame(0, 10, 32'h0CC, 4);
        deselect(0);
        tick();

        // 18-bit instance: write, then read-back of 16'h8001
        do_frame(1, 18, 32'h1ABCD, 0);
        deselect(1);
        do_frame(1, 18, 32'h20000, 0);
        chk("w16_rd_pending", {31'd0, rdp1}, 32'd1);
        deselect(1);
        do_frame(1, 18, 32'h30000, 0);
        tick();
        rd16 = 16'h8001;
        txv1 = 1'b1; txd1 = rd16;
        for (int k = 0; k < 16; k++) push_bit(1, cyc + 1 + k, rd16[15-k]);
        tick();
        txv1 = 1'b0; txd1 = '0;
        repeat (20) tick();
        chk("w16_read_done_rd_pending", {31'd0, rdp1}, 32'd0);
        deselect(1);
        repeat (3) tick();

        chk("evq0_drained", evq0.size(), 32'd0);
        chk("evq1_drained", evq1.size(), 32'd0);
        chk("mq0_drained", mq0.size(), 32'd0);
        chk("mq1_drained", mq1.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
